// File: rtl/zzacc.sv
// rtl/zzacc.sv - bit-plane partial-product accumulator with diagonal shift-and-add
module zzacc #(
    parameter int BPREC = 4,
    parameter int BWIN  = 10,
    parameter int BWACC = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [BPREC-1:0] pw,
    input  logic [BPREC-1:0] pd,
    input  logic             sw,
    input  logic             sd,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BWIN-1:0]  in_data,
    input  logic [BPREC-1:0] in_offw,
    input  logic [BPREC-1:0] in_offd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BWACC-1:0] out_data,
    output logic             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [BPREC-1:0]   pw_q, pw_d, pd_q, pd_d;
    logic               sw_q, sw_d, sd_q, sd_d;
    logic [BWACC-1:0]   acc_q, acc_d;
    logic [2*BPREC-1:0] cnt_q, cnt_d;
    logic [BPREC:0]     pdiag_q, pdiag_d;
    logic               err_q, err_d;

    logic [BPREC:0]     diag, shamt;
    logic               neg, accept, bad;
    logic [BWACC-1:0]   term_ext, term;
    logic [2*BPREC-1:0] cnt_inc, target;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign err       = err_q;

    assign accept   = in_valid && (state_q == ST_ACC);
    assign diag     = {1'b0, in_offw} + {1'b0, in_offd};
    assign neg      = (sw_q && (in_offw == '0)) ^ (sd_q && (in_offd == '0));
    assign term_ext = {{(BWACC-BWIN){in_data[BWIN-1]}}, in_data};
    assign term     = neg ? -term_ext : term_ext;
    // A diagonal that moves backwards is an error; it is folded in without shifting.
    assign shamt    = (diag >= pdiag_q) ? (diag - pdiag_q) : '0;
    assign bad      = (in_offw >= pw_q) || (in_offd >= pd_q) || (diag < pdiag_q);
    assign cnt_inc  = cnt_q + 1'b1;
    assign target   = {{BPREC{1'b0}}, pw_q} * {{BPREC{1'b0}}, pd_q};

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        pd_d    = pd_q;
        sw_d    = sw_q;
        sd_d    = sd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pdiag_d = pdiag_q;
        err_d   = err_q;
        if (start) begin
            pw_d    = pw;
            pd_d    = pd;
            sw_d    = sw;
            sd_d    = sd;
            acc_d   = '0;
            cnt_d   = '0;
            pdiag_d = '0;
            err_d   = 1'b0;
            state_d = ((state_q == ST_IDLE) && ((pw == '0) || (pd == '0))) ? ST_DONE : ST_ACC;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_d   = (acc_q << shamt) + term;
                        pdiag_d = diag;
                        cnt_d   = cnt_inc;
                        if (bad) err_d = 1'b1;
                        if (cnt_inc == target) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            pw_q    <= '0;
            pd_q    <= '0;
            sw_q    <= 1'b0;
            sd_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            pdiag_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            pd_q    <= pd_d;
            sw_q    <= sw_d;
            sd_q    <= sd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pdiag_q <= pdiag_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_zzacc.sv
// tb/tb_zzacc.sv - randomized scoreboard bench for zzacc
module tb_zzacc;
    localparam int BPREC = 4;
    localparam int BWIN  = 10;
    localparam int BWACC = 32;

    logic             clk = 1'b0;
    logic             clr, start, sw, sd, in_valid, in_ready, out_valid, out_ready, err;
    logic [BPREC-1:0] pw, pd, in_offw, in_offd;
    logic [BWIN-1:0]  in_data;
    logic [BWACC-1:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    logic [31:0] ev;

    always #5 clk = ~clk;

    zzacc #(.BPREC(BPREC), .BWIN(BWIN), .BWACC(BWACC)) dut (
        .clk(clk), .clr(clr), .start(start), .pw(pw), .pd(pd), .sw(sw), .sd(sd),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_offw(in_offw), .in_offd(in_offd), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err(err)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: a handshake seen between edges is consumed on the next edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", out_data, mon_e);
            end
        end
    end

    // Signed weight of one bit-plane; the MSB plane is negative for signed operands.
    function automatic longint plane_w(int off, int p, bit s);
        longint m;
        m = longint'(1) << (p - 1 - off);
        return (s && off == 0) ? -m : m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(int p_w, int p_d, bit s_w, bit s_d);
        pw = p_w[BPREC-1:0];
        pd = p_d[BPREC-1:0];
        sw = s_w;
        sd = s_d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_term(int ow, int od, int data);
        bit ok;
        ok = 1'b0;
        in_offw  = ow[BPREC-1:0];
        in_offd  = od[BPREC-1:0];
        in_data  = data[BWIN-1:0];
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL term_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (!out_valid) done = 1'b1;
            else begin
                out_ready = (k >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got out_valid=1 expected 0");
        end
    endtask

    // Sends every plane pair in non-decreasing diagonal order; expv is the signed product sum.
    task automatic run_op(int p_w, int p_d, bit s_w, bit s_d, output logic [31:0] expv);
        longint acc_m;
        int up, ow, od, data;
        acc_m = 0;
        do_start(p_w, p_d, s_w, s_d);
        for (int d = 0; d <= p_w + p_d - 2; d++) begin
            up = $urandom_range(0, 1);
            for (int j = 0; j < p_w; j++) begin
                ow = (up != 0) ? j : p_w - 1 - j;
                od = d - ow;
                if (od >= 0 && od < p_d) begin
                    data = int'($urandom_range(0, 1023)) - 512;
                    if ($urandom_range(0, 3) == 0) tick();
                    acc_m += longint'(data) * plane_w(ow, p_w, s_w) * plane_w(od, p_d, s_d);
                    send_term(ow, od, data);
                end
            end
        end
        expv = acc_m[31:0];
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; pw = '0; pd = '0; sw = 1'b0; sd = 1'b0;
        in_valid = 1'b0; in_data = '0; in_offw = '0; in_offd = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        start = 1'b1; pw = 4'd2; pd = 4'd2;
        tick();
        start = 1'b0;
        check("clr_over_start", 32'(in_ready), 32'd0);
        clr = 1'b0;
        tick();

        // Unsigned 2x2 example
        out_ready = 1'b1;
        do_start(2, 2, 0, 0);
        send_term(0, 0, 1); send_term(1, 0, 1); send_term(0, 1, 0); send_term(1, 1, 0);
        exp_q.push_back(32'd6);
        check("uns_valid", 32'(out_valid), 32'd1);
        tick();
        check("uns_idle_valid", 32'(out_valid), 32'd0);
        check("uns_idle_ready", 32'(in_ready), 32'd0);

        // Signed-weight example
        do_start(2, 2, 1, 0);
        send_term(0, 0, 1); send_term(1, 0, 1); send_term(0, 1, 0); send_term(1, 1, 0);
        exp_q.push_back(32'hFFFF_FFFE);
        check("sgn_valid", 32'(out_valid), 32'd1);
        tick();

        // Backpressure: 3*4 + 1*2 + 2*2 + 1*1 = 19
        out_ready = 1'b0;
        do_start(2, 2, 0, 0);
        send_term(0, 0, 3); send_term(0, 1, 1); send_term(1, 0, 2); send_term(1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'd19);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        exp_q.push_back(32'd19);
        out_ready = 1'b1;
        tick();
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready), 32'd0);

        // Abort by clr, then a fresh operation starting from zero
        do_start(2, 2, 0, 0);
        send_term(0, 0, 7); send_term(0, 1, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        check("abort_valid2", 32'(out_valid), 32'd0);
        do_start(2, 2, 0, 0);
        send_term(0, 0, 1); send_term(1, 0, 1); send_term(0, 1, 0); send_term(1, 1, 0);
        exp_q.push_back(32'd6);
        drain();

        // Abort by start in ACC
        do_start(3, 2, 1, 1);
        send_term(0, 0, 9); send_term(1, 0, 4);
        do_start(2, 2, 0, 0);
        check("restart_valid", 32'(out_valid), 32'd0);
        send_term(0, 0, 1); send_term(1, 0, 1); send_term(0, 1, 0); send_term(1, 1, 0);
        exp_q.push_back(32'd6);
        drain();

        // Diagonal regression: 4*1 + 2*2 + 3 + 4 (no shift) = 15
        out_ready = 1'b0;
        do_start(2, 2, 0, 0);
        send_term(0, 0, 1); send_term(1, 0, 2); send_term(1, 1, 3);
        check("err_before", 32'(err), 32'd0);
        send_term(0, 1, 4);
        check("err_set", 32'(err), 32'd1);
        check("err_valid", 32'(out_valid), 32'd1);
        check("err_data", out_data, 32'd15);
        exp_q.push_back(32'd15);
        out_ready = 1'b1;
        tick();
        check("err_held_idle", 32'(err), 32'd1);
        tick();
        check("err_held_idle2", 32'(err), 32'd1);
        // Out-of-range weight offset: diagonal 1 shifts a zero acc, result 5
        do_start(1, 1, 0, 0);
        check("err_cleared", 32'(err), 32'd0);
        send_term(1, 0, 5);
        check("err_offw", 32'(err), 32'd1);
        exp_q.push_back(32'd5);
        drain();

        // Zero precision
        out_ready = 1'b0;
        do_start(0, 3, 0, 0);
        check("zp_valid", 32'(out_valid), 32'd1);
        check("zp_data", out_data, 32'd0);
        check("zp_ready", 32'(in_ready), 32'd0);
        check("zp_err", 32'(err), 32'd0);
        exp_q.push_back(32'd0);
        out_ready = 1'b1;
        tick();
        check("zp_idle", 32'(out_valid), 32'd0);

        // in_valid in IDLE is ignored
        in_valid = 1'b1; in_offw = 4'hF; in_offd = 4'hF; in_data = 10'h3FF;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("idle_in_err", 32'(err), 32'd0);
        check("idle_in_valid", 32'(out_valid), 32'd0);

        // start in DONE with out_ready=1 consumes; with out_ready=0 drops
        out_ready = 1'b0;
        run_op(1, 2, 0, 1, ev);
        exp_q.push_back(ev);
        out_ready = 1'b1;
        do_start(2, 1, 1, 0);
        out_ready = 1'b0;
        check("done_start_acc", 32'(in_ready), 32'd1);
        send_term(0, 0, 3); send_term(1, 0, 2);
        check("drop_pending", 32'(out_valid), 32'd1);
        do_start(2, 2, 0, 0);
        check("drop_valid", 32'(out_valid), 32'd0);
        send_term(0, 0, 1); send_term(1, 0, 1); send_term(0, 1, 0); send_term(1, 1, 0);
        exp_q.push_back(32'd6);
        drain();

        for (int n = 0; n < 40; n++) begin
            int a, b, c, d;
            a = $urandom_range(1, 5);
            b = $urandom_range(1, 5);
            c = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            run_op(a, b, c != 0, d != 0, ev);
            exp_q.push_back(ev);
            check("rand_err", 32'(err), 32'd0);
            drain();
        end

        tick(); tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zzacc.md
ZZACC -- requirements
Module: zzacc

Interface
REQ-001 Parameter BPREC, default 4, bitwidth of the precision specifiers and of the plane offsets.
REQ-002 Parameter BWIN, default 10, bitwidth of the signed partial-product term.
REQ-003 Parameter BWACC, default 32, bitwidth of the accumulator and of the result.
REQ-004 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port clr  input  1  is the synchronous, active-high reset.
REQ-006 Port start  input  1  begins a new operation and latches pw, pd, sw and sd.
REQ-007 Port pw  input  BPREC  is the weight precision (number of bit-planes).
REQ-008 Port pd  input  BPREC  is the data precision (number of bit-planes).
REQ-009 Port sw  input  1  marks weights as two's-complement signed.
REQ-010 Port sd  input  1  marks data as two's-complement signed.
REQ-011 Port in_valid  input  1  qualifies one partial-product term.
REQ-012 Port in_ready  output  1  indicates that a term is accepted this cycle.
REQ-013 Port in_data  input  BWIN  is the signed term for plane pair (in_offw, in_offd).
REQ-014 Port in_offw  input  BPREC  is the weight-plane offset, where 0 is the MSB plane.
REQ-015 Port in_offd  input  BPREC  is the data-plane offset, where 0 is the MSB plane.
REQ-016 Port out_valid  output  1  indicates that the result is held on out_data.
REQ-017 Port out_ready  input  1  is the consumer acceptance of the result.
REQ-018 Port out_data  output  BWACC  is the signed accumulated product.
REQ-019 Port err  output  1  is a sticky protocol error flag.

Function
REQ-020 The block SHALL have the states IDLE, ACC and DONE.
REQ-021 When start=1, the block SHALL latch pw, pd, sw and sd, zero acc, the term count and prev_diag, and enter ACC from any state.
  - In IDLE, start=1 with pw=0 or pd=0 SHALL go directly to DONE with out_data=0.
REQ-022 in_ready SHALL be 1 only in ACC; a term is accepted when in_valid=1 and in_ready=1.
REQ-023 On acceptance:
  - diag=in_offw+in_offd, computed at BPREC+1 bits.
  - neg=(sw & in_offw==0) XOR (sd & in_offd==0).
  - acc <= (acc << (diag-prev_diag)) + (neg ? -sext(in_data) : sext(in_data)).
  - prev_diag <= diag; count <= count+1.
REQ-024 acc arithmetic SHALL be two's complement modulo 2^BWACC, with no saturation.
REQ-025 The count SHALL be 2*BPREC bits wide; the term whose acceptance makes count equal pw*pd SHALL move the block to DONE on the same edge.
REQ-026 The result SHALL appear on the cycle after the last term: out_valid=1 and out_data equal to the final acc.
REQ-027 In DONE, out_valid and out_data SHALL be held stable until out_ready=1; the block then returns to IDLE.
REQ-028 In DONE, start=1 SHALL begin a new operation.
  - The old result is dropped unless out_ready=1 in that same cycle, in which case it counts as consumed.
REQ-029 In IDLE and ACC, out_valid SHALL be 0.
REQ-030 An accepted term with in_offw>=pw, in_offd>=pd, or diag<prev_diag SHALL set err=1.
  - The term is still accumulated (the shift amount is treated as 0 when diag<prev_diag).
REQ-031 err SHALL clear only on clr or start.
REQ-032 start=1 in ACC SHALL abort the current operation without asserting out_valid.
REQ-033 in_valid=1 in IDLE or DONE SHALL be ignored and SHALL NOT set err.

Reset
REQ-034 When clr=1, the block SHALL enter IDLE and set acc=0, count=0, prev_diag=0, out_valid=0, out_data=0, err=0 and in_ready=0.
REQ-035 clr SHALL override start, in_valid and out_ready in the same cycle.
REQ-036 clr asserted mid-operation SHALL discard all partial state; no result is produced.

Verification
REQ-037 Unsigned case:
  - Stimulus: pw=2, pd=2, sw=sd=0; terms (0,0)=1, (1,0)=1, (0,1)=0, (1,1)=0; out_ready=1.
  - Response: out_valid one cycle after the 4th term, out_data=6.
REQ-038 Signed-weight case:
  - Stimulus: same terms as REQ-037 with sw=1.
  - Response: out_data=-2 (0xFFFFFFFE).
REQ-039 Backpressure case:
  - Stimulus: out_ready=0 for 5 cycles after out_valid.
  - Response: out_data stable, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-040 Abort case:
  - Stimulus: clr after 2 of 4 terms, then start.
  - Response: no out_valid; the new operation starts with acc=0.
REQ-041 Error case:
  - Stimulus: pw=2, pd=2 with term (1,1) sent before (0,1).
  - Response: err=1 and held until the next start.
REQ-042 Zero-precision case:
  - Stimulus: start with pw=0.
  - Response: out_valid=1 with out_data=0 on the next cycle; in_ready stays 0.
